vga_sync_receiver: RTL and testbench
====================================

Name: vga_sync_receiver

Overview:
Receive end of the team's VGA link. Takes a raw 3-bit RGB pixel bus plus active-low hsync/vsync and measures line and frame timing. Locks onto a stable mode and recovers pixel coordinates, data-enable and pixel data for downstream capture or checking logic. Sits in loopback benches and capture paths, paired with the existing sync/pixel generator at the 25 MHz pixel strobe.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_SYNC, 96, hsync width in pixel strobes
H_BP, 48, back porch after hsync deassertion
V_ACTIVE, 480, visible lines per frame
V_SYNC, 2, vsync width in lines
V_BP, 33, lines after vsync deassertion before active video
LOCK_FRAMES, 2, consecutive matching frames needed to lock (1..7)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pix_en  in  1  pixel-rate strobe; all state advances only when high
hsync_in  in  1  horizontal sync, active-low
vsync_in  in  1  vertical sync, active-low
pixel_in  in  3  RGB pixel
de  out  1  active-video qualifier, only when locked
x  out  10  active-area column 0..H_ACTIVE-1
y  out  10  active-area row 0..V_ACTIVE-1
pixel_out  out  3  pixel aligned to x/y/de
frame_start  out  1  one-clk pulse on vsync assertion while locked
locked  out  1  mode lock
h_total  out  10  last measured line length in strobes
v_total  out  10  last measured frame length in lines
sync_err  out  1  one-clk pulse on timing mismatch or loss

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous, active-low (rst_n). rst_n low at any edge zeroes every output and counter and forces SEARCH; mid-frame reset discards all lock history.
- pix_en low: all state holds. Pulse outputs (frame_start, sync_err) are zero in non-strobe cycles.
- Stage 1 registers hsync_in/vsync_in/pixel_in on pix_en. Edge detection compares stage-1 syncs to their previous sample. Assertion edge = 1->0.
- hcnt (10b): +1 per strobe, saturating at 1023. On hsync edge: h_total <= hcnt+1, hcnt <= 0.
- vcnt (10b): +1 per hsync edge, saturating. On vsync edge: v_total <= vcnt (+1 if an hsync edge coincides), vcnt <= 0. On a coincident vsync edge, the vsync clear wins.
- Active when hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- Outputs are registered: de/x/y/pixel_out valid 2 strobes after the pixel enters pixel_in.
- When !de: x=0, y=0, pixel_out=0. x = hcnt-(H_SYNC+H_BP); y = vcnt-(V_SYNC+V_BP).
- FSM SEARCH -> MEASURE -> VERIFY -> LOCKED:
  - SEARCH: first vsync edge -> MEASURE.
  - MEASURE: next vsync edge latches ref_h = last h_total and ref_v = v_total -> VERIFY, match_cnt=0. Only the first line after entry is exempt from checks.
  - VERIFY: any hsync edge with h_total != ref_h -> SEARCH + sync_err. On vsync edge, v_total == ref_v increments match_cnt; reaching LOCK_FRAMES -> LOCKED, else stay. v_total != ref_v -> SEARCH + sync_err.
  - LOCKED: same checks. Any mismatch or hcnt saturation -> SEARCH, sync_err pulse, locked low the same edge.
- Lock therefore rises on the (LOCK_FRAMES+2)-th vsync edge after leaving reset.
- Saturation of hcnt (no hsync for 1023 strobes) counts as a mismatch in VERIFY and LOCKED.

Optional Feature:
VGA_RX_CRC_EN. When defined, adds output frame_crc[15:0]: CRC-16-CCITT (poly 0x1021, init 0xFFFF) over pixel_out zero-extended to 8 bits, for every strobe with de=1. frame_crc is latched on each frame_start and the accumulator reinitialised on the same edge; it resets to 0. When undefined, the port and logic are absent and all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg: the 640x480 timing constants (H/V active, front porch, sync, back porch, totals 800/525), FSM state encoding, and CRC polynomial/init.
- One sub-module, vga_sync_edge: input register stage plus assertion-edge detectors for hsync/vsync, gated by pix_en.

Test Plan:
- Ideal 800x525 timing, pix_en every 4th clk, 5 frames -> locked rises at 4th vsync edge; h_total=800, v_total=525; sync_err never pulses.
- Locked, pixel_in=3'b101 at first active pixel of first active line -> 2 strobes later de=1, x=0, y=0, pixel_out=101; de count per frame = 307200; last de has x=639, y=479.
- Locked, one line shortened to 799 strobes -> one sync_err pulse, locked=0 at that hsync edge; relock after 4 further vsync edges.
- Locked, hsync held high -> at hcnt=1023 sync_err pulse, locked=0, de stays 0 thereafter.
- rst_n low for 1 clk mid-frame while locked -> all outputs 0 next clk; relock on 4th vsync edge after reset.
- VGA_RX_CRC_EN, constant pixel_in=3'b111 across 2 locked frames -> frame_crc identical at both frame_start pulses and equal to the bench model value.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA receive path.
// Holds the 640x480@60 reference timing (active, porches, sync, totals),
// the receiver FSM state encoding, CRC-16-CCITT constants and small helpers.
package vga_timing_pkg;

  localparam int unsigned PIXEL_W      = 3;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam logic [15:0] CRC_POLY     = 16'h1021;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_VERIFY,
    ST_LOCKED
  } rx_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == '1) ? v : v + 10'd1;
  endfunction

  // One byte through CRC-16-CCITT, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Input register stage for the VGA receiver.
// Samples hsync/vsync/pixel on each pix_en strobe and flags sync assertion
// (1->0) edges between the last two samples.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   pix_en            pixel strobe; registers only advance when high
//   hsync_in/vsync_in raw active-low syncs
//   pixel_in          raw RGB pixel
//   pixel_dly         pixel aligned with the sample pair the edge flags describe
//   hsync_fall        hsync assertion edge between previous and current sample
//   vsync_fall        vsync assertion edge between previous and current sample
module vga_sync_edge
  import vga_timing_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [PIXEL_W-1:0] pixel_in,
  output logic [PIXEL_W-1:0] pixel_dly,
  output logic               hsync_fall,
  output logic               vsync_fall
);

  logic               hsync_q;
  logic               hsync_prev;
  logic               vsync_q;
  logic               vsync_prev;
  logic [PIXEL_W-1:0] pixel_q;

  // Syncs reset to their idle (high) level so a line already in sync at
  // reset release is seen as a fresh assertion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q    <= 1'b1;
      hsync_prev <= 1'b1;
      vsync_q    <= 1'b1;
      vsync_prev <= 1'b1;
      pixel_q    <= '0;
      pixel_dly  <= '0;
    end else if (pix_en) begin
      hsync_prev <= hsync_q;
      hsync_q    <= hsync_in;
      vsync_prev <= vsync_q;
      vsync_q    <= vsync_in;
      pixel_q    <= pixel_in;
      pixel_dly  <= pixel_q;
    end
  end

  // The edge flags describe sample pair (prev, q); the counters consume them on
  // the following strobe, so pixel_dly (one sample behind q) lines up with them.
  assign hsync_fall = hsync_prev & ~hsync_q;
  assign vsync_fall = vsync_prev & ~vsync_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA link receiver: measures line/frame timing from active-low hsync/vsync,
// locks onto a stable mode and recovers pixel coordinates, data-enable and
// pixel data.
// Optional build macro VGA_RX_CRC_EN adds frame_crc (CRC-16-CCITT over each
// locked frame's active pixels, latched on frame_start).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   pix_en              pixel strobe; all state advances only when high
//   hsync_in, vsync_in  active-low syncs
//   pixel_in            RGB pixel
//   de, x, y, pixel_out recovered active video (zero when de is low)
//   frame_start         one-clk pulse on vsync assertion while locked
//   locked              mode lock
//   h_total, v_total    last measured line length (strobes) / frame length (lines)
//   sync_err            one-clk pulse on timing mismatch or hsync loss
//   frame_crc           (VGA_RX_CRC_EN only) CRC of the previous locked frame
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  pixel_in,
  output logic        de,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic [2:0]  pixel_out,
  output logic        frame_start,
  output logic        locked,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total,
  output logic        sync_err
`ifdef VGA_RX_CRC_EN
  ,
  output logic [15:0] frame_crc
`endif
);

  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [2:0] LOCK_N  = 3'(LOCK_FRAMES);

  logic [2:0] pixel_dly;
  logic       hfall;
  logic       vfall;

  vga_sync_edge u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .pixel_in   (pixel_in),
    .pixel_dly  (pixel_dly),
    .hsync_fall (hfall),
    .vsync_fall (vfall)
  );

  rx_state_e  state;
  rx_state_e  state_next;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [9:0] ref_h;
  logic [9:0] ref_v;
  logic [2:0] match_cnt;
  logic [2:0] match_next;
  logic [2:0] match_inc;
  logic [9:0] h_meas;
  logic [9:0] v_meas;
  logic       err;
  logic       latch_ref;
  logic       frame_start_next;
  logic       act;

  // Measurement produced by the edge being consumed this strobe.
  assign h_meas    = sat_inc10(hcnt);
  assign v_meas    = hfall ? sat_inc10(vcnt) : vcnt;
  assign match_inc = match_cnt + 3'd1;

  assign act = (hcnt >= H_START) && (hcnt < H_END) &&
               (vcnt >= V_START) && (vcnt < V_END);

  always_comb begin
    state_next       = state;
    match_next       = match_cnt;
    err              = 1'b0;
    latch_ref        = 1'b0;
    frame_start_next = 1'b0;
    if (pix_en) begin
      unique case (state)
        ST_SEARCH: begin
          if (vfall) state_next = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (vfall) begin
            state_next = ST_VERIFY;
            latch_ref  = 1'b1;
            match_next = '0;
          end
        end
        ST_VERIFY, ST_LOCKED: begin
          // hcnt about to reach 1023 without an hsync counts as loss of sync.
          if ((hfall && (h_meas != ref_h)) ||
              (vfall && (v_meas != ref_v)) ||
              (!hfall && (hcnt >= 10'd1022))) begin
            err        = 1'b1;
            state_next = ST_SEARCH;
            match_next = '0;
          end else if (vfall) begin
            if (state == ST_VERIFY) begin
              match_next = match_inc;
              if (match_inc >= LOCK_N) state_next = ST_LOCKED;
            end else begin
              frame_start_next = 1'b1;
            end
          end
        end
        default: state_next = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_SEARCH;
      match_cnt   <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      ref_h       <= '0;
      ref_v       <= '0;
      h_total     <= '0;
      v_total     <= '0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      pixel_out   <= '0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else if (pix_en) begin
      state     <= state_next;
      match_cnt <= match_next;
      hcnt      <= hfall ? '0 : sat_inc10(hcnt);
      if (hfall) h_total <= h_meas;
      // A coincident vsync edge clears vcnt rather than incrementing it.
      if (vfall) begin
        vcnt    <= '0;
        v_total <= v_meas;
      end else if (hfall) begin
        vcnt <= sat_inc10(vcnt);
      end
      if (latch_ref) begin
        ref_h <= hfall ? h_meas : h_total;
        ref_v <= v_meas;
      end
      // Gate on the next state so de never outlives locked.
      if (act && (state_next == ST_LOCKED)) begin
        de        <= 1'b1;
        x         <= hcnt - H_START;
        y         <= vcnt - V_START;
        pixel_out <= pixel_dly;
      end else begin
        de        <= 1'b0;
        x         <= '0;
        y         <= '0;
        pixel_out <= '0;
      end
      frame_start <= frame_start_next;
      sync_err    <= err;
    end else begin
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end
  end

  assign locked = (state == ST_LOCKED);

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_acc   <= CRC_INIT;
      frame_crc <= '0;
    end else if (pix_en) begin
      if (frame_start_next) begin
        frame_crc <= crc_acc;
        crc_acc   <= CRC_INIT;
      end else if (state != ST_LOCKED) begin
        crc_acc <= CRC_INIT;
      end else if (de) begin
        crc_acc <= crc16_byte(crc_acc, {5'b0, pixel_out});
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver on a reduced 28x15 timing.
module tb_vga_sync_receiver;

  localparam int HS = 4, HBP = 4, HA = 16, HFP = 4;
  localparam int HT = HS + HBP + HA + HFP;
  localparam int VS = 2, VBP = 3, VA = 8, VFP = 2;
  localparam int VT = VS + VBP + VA + VFP;
  localparam int LF = 2;
  localparam int HSTART = HS + HBP;
  localparam int VSTART = VS + VBP;
  localparam int EV_FS = 1, EV_ERR = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic       hsync_in;
  logic       vsync_in;
  logic [2:0] pixel_in;
  logic       de;
  logic [9:0] x;
  logic [9:0] y;
  logic [2:0] pixel_out;
  logic       frame_start;
  logic       locked;
  logic [9:0] h_total;
  logic [9:0] v_total;
  logic       sync_err;
`ifdef VGA_RX_CRC_EN
  logic [15:0] frame_crc;
`endif

  vga_sync_receiver #(
    .H_ACTIVE   (HA),
    .H_SYNC     (HS),
    .H_BP       (HBP),
    .V_ACTIVE   (VA),
    .V_SYNC     (VS),
    .V_BP       (VBP),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .pixel_in   (pixel_in),
    .de         (de),
    .x          (x),
    .y          (y),
    .pixel_out  (pixel_out),
    .frame_start(frame_start),
    .locked     (locked),
    .h_total    (h_total),
    .v_total    (v_total),
    .sync_err   (sync_err)
`ifdef VGA_RX_CRC_EN
    ,
    .frame_crc  (frame_crc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] p;
  } pix_t;

  pix_t        pq[$];
  int          evq[$];
  logic [15:0] crcq[$];

  int          vectors = 0;
  int          miscompares = 0;
  int          fs = 0;
  bit          err_next = 0;
  bit          const_mode = 0;
  logic [15:0] crc_m = 16'hFFFF;
  logic        en_d = 1'b0;

  always @(posedge clk) en_d <= pix_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c_in, input logic [2:0] p);
    logic [15:0] c;
    logic [7:0]  d;
    logic        fb;
    c = c_in;
    d = {5'b0, p};
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [2:0] pat(input int px, input int py);
    return const_mode ? 3'd7 : 3'((px + py + 5) & 7);
  endfunction

  task automatic strobe(input logic h, input logic v, input logic [2:0] p);
    @(negedge clk);
    hsync_in = h;
    vsync_in = v;
    pixel_in = p;
    pix_en   = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_line(input int line, input int len);
    logic       h;
    logic       v;
    logic [2:0] p;
    pix_t       e;
    for (int pos = 0; pos < len; pos++) begin
      if (pos == 0 && err_next) begin
        evq.push_back(EV_ERR);
        err_next = 0;
        fs       = 0;
        crc_m    = 16'hFFFF;
      end
      if (pos == 0 && line == 0) begin
        fs++;
        if (fs >= LF + 3) begin
          evq.push_back(EV_FS);
          crcq.push_back(crc_m);
        end
        crc_m = 16'hFFFF;
      end
      h = (pos < HS) ? 1'b0 : 1'b1;
      v = (line < VS) ? 1'b0 : 1'b1;
      p = 3'(pos);
      if (pos >= HSTART && pos < HSTART + HA && line >= VSTART && line < VSTART + VA) begin
        p = pat(pos - HSTART, line - VSTART);
        if (fs >= LF + 2) begin
          e.x = 10'(pos - HSTART);
          e.y = 10'(line - VSTART);
          e.p = p;
          pq.push_back(e);
          crc_m = crc_step(crc_m, p);
        end
      end
      strobe(h, v, p);
      if (line == 0 && pos == 0) check("locked_before_vedge", locked, (fs >= LF + 3) ? 1 : 0);
      if (line == 0 && pos == 1) check("locked_after_vedge", locked, (fs >= LF + 2) ? 1 : 0);
    end
  endtask

  task automatic lines(input int first, input int last, input int short_line);
    for (int l = first; l <= last; l++) begin
      send_line(l, (l == short_line) ? HT - 1 : HT);
      if (l == short_line) err_next = 1;
    end
  endtask

  task automatic end_frame_checks();
    check("locked_end_frame", locked, (fs >= LF + 2) ? 1 : 0);
    if (fs >= 2) begin
      check("h_total", h_total, HT);
      check("v_total", v_total, VT);
    end
  endtask

  task automatic full_frames(input int n);
    for (int i = 0; i < n; i++) begin
      lines(0, VT - 1, -1);
      end_frame_checks();
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents output.
  initial begin
    int   ev;
    pix_t e;
    forever begin
      @(negedge clk);
      if (frame_start) begin
        check("frame_start_on_strobe", en_d, 1);
        if (evq.size() == 0) check("unexpected_frame_start", 1, 0);
        else begin
          ev = evq.pop_front();
          check("event_frame_start", EV_FS, ev);
        end
`ifdef VGA_RX_CRC_EN
        if (crcq.size() == 0) check("unexpected_frame_crc", 1, 0);
        else check("frame_crc", frame_crc, crcq.pop_front());
`endif
      end
      if (sync_err) begin
        check("sync_err_on_strobe", en_d, 1);
        if (evq.size() == 0) check("unexpected_sync_err", 1, 0);
        else begin
          ev = evq.pop_front();
          check("event_sync_err", EV_ERR, ev);
        end
      end
      if (en_d && rst_n) begin
        if (de) begin
          if (pq.size() == 0) check("unexpected_de", 1, 0);
          else begin
            e = pq.pop_front();
            check("pixel_xy", {9'b0, x, y, pixel_out}, {9'b0, e});
          end
        end else begin
          check("idle_zero", {19'b0, x, y, pixel_out}, 0);
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    pix_en   = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    pixel_in = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_video", {de, x, y, pixel_out}, 0);
    check("reset_flags", {frame_start, locked, sync_err}, 0);
    check("reset_totals", {h_total, v_total}, 0);
    rst_n = 1'b1;
    repeat (3) strobe(1'b1, 1'b1, 3'd0);

    // Clean timing: lock on the 4th vsync edge, then locked frames.
    full_frames(5);

    // One short line while locked, then relock.
    lines(0, VT - 1, 7);
    end_frame_checks();
    full_frames(4);

    // hsync stops while locked: saturation loss.
    lines(0, 6, -1);
    evq.push_back(EV_ERR);
    fs    = 0;
    crc_m = 16'hFFFF;
    repeat (1100) strobe(1'b1, 1'b1, 3'b110);
    check("locked_after_sat", locked, 0);
    full_frames(4);

    // Mid-frame reset while locked.
    lines(0, 6, -1);
    check("locked_before_reset", locked, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_video", {de, x, y, pixel_out}, 0);
    check("midreset_flags", {frame_start, locked, sync_err}, 0);
    check("midreset_totals", {h_total, v_total}, 0);
    rst_n = 1'b1;
    fs    = 0;
    crc_m = 16'hFFFF;
    lines(7, VT - 1, -1);
    full_frames(4);

    // Constant white frames for the frame CRC.
    const_mode = 1;
    full_frames(3);
    lines(0, 1, -1);

    repeat (4) strobe(1'b1, 1'b1, 3'd0);
    check("pixel_queue_drained", pq.size(), 0);
    check("event_queue_drained", evq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
